// File: rtl/dct_pkg.sv
// Shared types for the 2-D DCT datapath: block size, sample word and row/column vector.
package dct_pkg;
  localparam int unsigned DCT_N = 8;
  localparam int unsigned DCT_W = 32;
  localparam int unsigned IDX_W = 3;

  typedef logic signed [DCT_W-1:0] sample_t;
  typedef sample_t [DCT_N-1:0]     vec_t;
endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 sample bank: written a row at a time, read a column at a time.
module dct_tp_bank
  import dct_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wrow,
  input  vec_t             wdata,
  input  logic [IDX_W-1:0] rcol,
  output vec_t             rdata
);

  vec_t mem [DCT_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DCT_N; r++) begin
        mem[r] <= '0;
      end
    end else if (we) begin
      mem[wrow] <= wdata;
    end
  end

  // Column read: lane r carries element (r, rcol)
  always_comb begin
    rdata = '0;
    for (int unsigned r = 0; r < DCT_N; r++) begin
      rdata[r] = mem[r][rcol];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the row and column 1-D DCT passes.
// Rows fill one bank while the other is drained column by column.
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int unsigned IN_W = 32,
  parameter int unsigned N    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N*IN_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N*IN_W-1:0] m_data,
  output logic [2:0]        m_col,
  output logic              m_last
);

  if (N != DCT_N || IN_W != DCT_W) begin : g_bad_param
    $error("dct_transpose_buf supports only N=8 and IN_W=32");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DCT_N - 1);

  logic             wbank;
  logic             rbank;
  logic [IDX_W-1:0] wrow;
  logic [IDX_W-1:0] rcol;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic [1:0]       bank_we;
  logic             wr_fire;
  logic             rd_fire;
  vec_t             wvec;
  vec_t             rdata [2];

  assign s_ready = !full[wbank];
  assign m_valid = full[rbank];

  // Flush suppresses both handshakes in its cycle
  assign wr_fire = s_valid && s_ready && !flush;
  assign rd_fire = m_valid && m_ready && !flush;

  assign wvec = vec_t'(s_data);

  always_comb begin
    full_nxt = full;
    if (wr_fire && wrow == LAST_IDX) full_nxt[wbank] = 1'b1;
    if (rd_fire && rcol == LAST_IDX) full_nxt[rbank] = 1'b0;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_fire && (wbank == 1'(b));

    dct_tp_bank u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we[b]),
      .wrow  (wrow),
      .wdata (wvec),
      .rcol  (rcol),
      .rdata (rdata[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      wrow  <= '0;
      rcol  <= '0;
      full  <= '0;
    end else if (flush) begin
      wbank <= 1'b0;
      rbank <= 1'b0;
      wrow  <= '0;
      rcol  <= '0;
      full  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wrow <= wrow + IDX_W'(1);
        if (wrow == LAST_IDX) wbank <= !wbank;
      end
      if (rd_fire) begin
        rcol <= rcol + IDX_W'(1);
        if (rcol == LAST_IDX) rbank <= !rbank;
      end
    end
  end

  assign m_data = (N*IN_W)'(rdata[rbank]);
  assign m_col  = rcol;
  assign m_last = (rcol == LAST_IDX);

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed and scoreboard bench for the ping-pong 8x8 transpose buffer.
module tb_dct_transpose_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [255:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [255:0] m_data;
  logic [2:0]   m_col;
  logic         m_last;

  int total = 0;
  int bad   = 0;

  logic [31:0] rmem [64][8][8];

  always #5 clk = ~clk;

  dct_transpose_buf #(.IN_W(32), .N(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_col   (m_col),
    .m_last  (m_last)
  );

  function automatic logic [31:0] elem(int b, int r, int c);
    return 32'(256 * b + 16 * r + c);
  endfunction

  function automatic logic [255:0] row_vec(int b, int r);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = elem(b, r, k);
    return v;
  endfunction

  function automatic logic [255:0] col_vec(int b, int c);
    logic [255:0] v;
    for (int r = 0; r < 8; r++) v[r*32 +: 32] = elem(b, r, c);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    #3;
    total++;
    if ({s_ready, m_valid, m_col, m_last} !== 6'b10_000_0 || m_data !== 256'd0) begin
      bad++;
      $display("FAIL reset got rdy=%0b vld=%0b col=%0d last=%0b data=%h exp rdy=1 vld=0 col=0 last=0 data=0",
               s_ready, m_valid, m_col, m_last, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_block();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      s_data = row_vec(0, r);
      total++;
      if ({s_ready, m_valid} !== 2'b10) begin
        bad++;
        $display("FAIL single_write r=%0d got rdy=%0b vld=%0b exp rdy=1 vld=0", r, s_ready, m_valid);
      end
      tick();
    end
    s_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total++;
      if ({m_valid, m_col, m_last} !== {1'b1, 3'(c), (c == 7)} || m_data !== col_vec(0, c)) begin
        bad++;
        $display("FAIL single_col c=%0d got vld=%0b col=%0d last=%0b data=%h exp data=%h",
                 c, m_valid, m_col, m_last, m_data, col_vec(0, c));
      end
      tick();
    end
    m_ready = 1'b0;
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drained got vld=%0b exp 0", m_valid);
    end
  endtask

  task automatic test_stream();
    int rows = 0, cols = 0, cyc = 0, first_v = -1, first_b1 = -1;
    m_ready = 1'b1;
    while (cols < 32 && cyc < 100) begin
      if (rows < 32) begin
        s_valid = 1'b1;
        s_data  = row_vec(rows / 8, rows % 8);
        total++;
        if (s_ready !== 1'b1) begin
          bad++;
          $display("FAIL stream_ready row=%0d got rdy=%0b exp 1", rows, s_ready);
        end
      end else begin
        s_valid = 1'b0;
      end
      if (m_valid === 1'b1) begin
        if (first_v < 0) first_v = cyc;
        if (cols == 8) first_b1 = cyc;
        total++;
        if (m_col !== 3'(cols % 8) || m_last !== (cols % 8 == 7) || m_data !== col_vec(cols / 8, cols % 8)) begin
          bad++;
          $display("FAIL stream_col n=%0d got col=%0d last=%0b data=%h exp col=%0d data=%h",
                   cols, m_col, m_last, m_data, cols % 8, col_vec(cols / 8, cols % 8));
        end
        cols++;
      end
      if (rows < 32 && s_ready === 1'b1) rows++;
      tick();
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    total++;
    if (cols != 32) begin
      bad++;
      $display("FAIL stream_count got cols=%0d exp 32", cols);
    end
    total++;
    if (first_b1 - first_v != 8) begin
      bad++;
      $display("FAIL stream_latency got %0d exp 8", first_b1 - first_v);
    end
  endtask

  task automatic test_back_pressure();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = row_vec(i / 8, i % 8);
      total++;
      if (s_ready !== 1'b1) begin
        bad++;
        $display("FAIL bp_fill row=%0d got rdy=%0b exp 1", i, s_ready);
      end
      tick();
    end
    s_data = row_vec(2, 0);
    for (int h = 0; h < 4; h++) begin
      total++;
      if ({s_ready, m_valid, m_col} !== 5'b01_000 || m_data !== col_vec(0, 0)) begin
        bad++;
        $display("FAIL bp_hold h=%0d got rdy=%0b vld=%0b col=%0d data=%h exp rdy=0 vld=1 col=0 data=%h",
                 h, s_ready, m_valid, m_col, m_data, col_vec(0, 0));
      end
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_col !== 3'(c) || m_data !== col_vec(0, c)) begin
        bad++;
        $display("FAIL bp_blk0 c=%0d got rdy=%0b vld=%0b col=%0d data=%h exp rdy=0 data=%h",
                 c, s_ready, m_valid, m_col, m_data, col_vec(0, c));
      end
      tick();
    end
    total++;
    if (s_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got rdy=%0b exp 1", s_ready);
    end
    for (int c = 0; c < 8; c++) begin
      total++;
      if (m_valid !== 1'b1 || m_col !== 3'(c) || m_last !== (c == 7) || m_data !== col_vec(1, c)) begin
        bad++;
        $display("FAIL bp_blk1 c=%0d got vld=%0b col=%0d data=%h exp data=%h",
                 c, m_valid, m_col, m_data, col_vec(1, c));
      end
      tick();
    end
    m_ready = 1'b0;
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drained got vld=%0b exp 0", m_valid);
    end
  endtask

  task automatic test_random();
    int wb = 0, wr = 0, rb = 0, rc = 0, cyc = 0;
    logic         prev_hold = 1'b0;
    logic [255:0] prev_data = '0;
    logic [255:0] exp_col;
    for (int b = 0; b < 64; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          rmem[b][r][c] = $urandom;
          if ((b + r + c) % 7 == 0) rmem[b][r][c] = 32'h8000_0000;
          else if ((b + r + c) % 7 == 3) rmem[b][r][c] = 32'h7fff_ffff;
        end
    while (rb < 64 && cyc < 5000) begin
      s_valid = (wb < 64) && ($urandom_range(0, 1) == 1);
      s_data  = '0;
      if (wb < 64) for (int k = 0; k < 8; k++) s_data[k*32 +: 32] = rmem[wb][wr][k];
      m_ready = ($urandom_range(0, 1) == 1);
      if (prev_hold) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          bad++;
          $display("FAIL rand_stable blk=%0d col=%0d got vld=%0b data=%h exp data=%h",
                   rb, rc, m_valid, m_data, prev_data);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        for (int r = 0; r < 8; r++) exp_col[r*32 +: 32] = rmem[rb][r][rc];
        total++;
        if (m_col !== 3'(rc) || m_last !== (rc == 7) || m_data !== exp_col) begin
          bad++;
          $display("FAIL rand_col blk=%0d col=%0d got col=%0d last=%0b data=%h exp data=%h",
                   rb, rc, m_col, m_last, m_data, exp_col);
        end
        if (rc == 7) begin rc = 0; rb++; end else rc++;
      end
      prev_hold = (m_valid === 1'b1) && !m_ready;
      prev_data = m_data;
      if (s_valid && s_ready === 1'b1) begin
        if (wr == 7) begin wr = 0; wb++; end else wr++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    total++;
    if (rb != 64 || wb != 64) begin
      bad++;
      $display("FAIL rand_count got wr_blocks=%0d rd_blocks=%0d exp 64 64", wb, rb);
    end
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_extra got vld=%0b exp 0", m_valid);
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      s_data = row_vec(10, r);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      s_data  = row_vec(11, i);
      m_ready = (i < 4);
      if (i < 4) begin
        total++;
        if (m_valid !== 1'b1 || m_col !== 3'(i) || m_data !== col_vec(10, i)) begin
          bad++;
          $display("FAIL flush_pre c=%0d got vld=%0b col=%0d data=%h exp data=%h",
                   i, m_valid, m_col, m_data, col_vec(10, i));
        end
      end
      tick();
    end
    flush = 1'b1; s_data = row_vec(11, 5); m_ready = 1'b1;
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    total++;
    if ({s_ready, m_valid, m_col, m_last} !== 6'b10_000_0) begin
      bad++;
      $display("FAIL flush_state got rdy=%0b vld=%0b col=%0d last=%0b exp rdy=1 vld=0 col=0 last=0",
               s_ready, m_valid, m_col, m_last);
    end
    s_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      s_data = row_vec(12, r);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (m_valid !== 1'b1 || m_col !== 3'(c) || m_last !== (c == 7) || m_data !== col_vec(12, c)) begin
        bad++;
        $display("FAIL flush_fresh c=%0d got vld=%0b col=%0d data=%h exp data=%h",
                 c, m_valid, m_col, m_data, col_vec(12, c));
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      s_data = (i < 8) ? row_vec(20, i) : row_vec(21, i - 8);
      tick();
    end
    s_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_ready, m_valid, m_col, m_last} !== 6'b10_000_0 || m_data !== 256'd0) begin
      bad++;
      $display("FAIL async_reset got rdy=%0b vld=%0b col=%0d last=%0b data=%h exp rdy=1 vld=0 col=0 last=0 data=0",
               s_ready, m_valid, m_col, m_last, m_data);
    end
    #2;
    rst_n = 1'b1;
    tick();
    s_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      s_data = row_vec(22, r);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      total++;
      if (m_valid !== 1'b1 || m_col !== 3'(c) || m_last !== (c == 7) || m_data !== col_vec(22, c)) begin
        bad++;
        $display("FAIL async_after c=%0d got vld=%0b col=%0d data=%h exp data=%h",
                 c, m_valid, m_col, m_data, col_vec(22, c));
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_stream();
    test_back_pressure();
    test_random();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
